// File: rtl/msg_framer_pkg.sv
// Shared definitions for the message framer: state encoding, frame geometry,
// default sync byte and the frame checksum.
package msg_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEQ  = 3'd2,
        ST_D0   = 3'd3,
        ST_D1   = 3'd4,
        ST_D2   = 3'd5,
        ST_D3   = 3'd6,
        ST_CHK  = 3'd7
    } framer_state_t;

    localparam int         FRAME_LEN         = 7;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Checksum covers SEQ and the four data bytes; the sync byte is excluded.
    function automatic logic [7:0] frame_chk(input logic [7:0] seq, input logic [31:0] word);
        return seq + word[7:0] + word[15:8] + word[23:16] + word[31:24];
    endfunction

endpackage

// File: rtl/msg_framer.sv
// Serialises 32-bit message words into 7-byte frames:
// SYNC, SEQ, D0..D3 (little-endian), CHK. Zero-bubble between frames.
module msg_framer
    import msg_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_data,
    input  logic        word_avail,
    output logic        word_pull,
    output logic [7:0]  out_data,
    output logic        out_avail,
    input  logic        out_pull
);

    framer_state_t r_state;
    logic [31:0]   r_word;
    logic [7:0]    r_seq;
    logic [7:0]    r_out_data;
    logic          r_out_avail;

    logic          w_byte_xfer;
    logic          w_word_xfer;

    // Reset gating keeps word_pull low for the whole time rst is held.
    assign word_pull   = !rst && ((r_state == ST_IDLE) || ((r_state == ST_CHK) && out_pull));
    assign w_byte_xfer = r_out_avail && out_pull;
    assign w_word_xfer = word_avail && word_pull;

    assign out_data  = r_out_data;
    assign out_avail = r_out_avail;

    // Frame sequencer: each state's byte is loaded on the edge that enters it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word      <= 32'h0000_0000;
            r_seq       <= 8'h00;
            r_out_data  <= 8'h00;
            r_out_avail <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_word_xfer) begin
                        r_word      <= word_data;
                        r_state     <= ST_SYNC;
                        r_out_data  <= SYNC_BYTE;
                        r_out_avail <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (w_byte_xfer) begin
                        r_state    <= ST_SEQ;
                        r_out_data <= r_seq;
                    end
                end
                ST_SEQ: begin
                    if (w_byte_xfer) begin
                        r_state    <= ST_D0;
                        r_out_data <= r_word[7:0];
                    end
                end
                ST_D0: begin
                    if (w_byte_xfer) begin
                        r_state    <= ST_D1;
                        r_out_data <= r_word[15:8];
                    end
                end
                ST_D1: begin
                    if (w_byte_xfer) begin
                        r_state    <= ST_D2;
                        r_out_data <= r_word[23:16];
                    end
                end
                ST_D2: begin
                    if (w_byte_xfer) begin
                        r_state    <= ST_D3;
                        r_out_data <= r_word[31:24];
                    end
                end
                ST_D3: begin
                    if (w_byte_xfer) begin
                        r_state    <= ST_CHK;
                        r_out_data <= frame_chk(r_seq, r_word);
                    end
                end
                ST_CHK: begin
                    if (w_byte_xfer) begin
                        r_seq <= r_seq + 8'd1;
                        if (w_word_xfer) begin
                            r_word     <= word_data;
                            r_state    <= ST_SYNC;
                            r_out_data <= SYNC_BYTE;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_out_data  <= 8'h00;
                            r_out_avail <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_data  <= 8'h00;
                    r_out_avail <= 1'b0;
                end
            endcase
        end
    end

endmodule
